// File: rtl/codificador_pt2262_param.sv
// ---------------------------------------------------------------------------
// codificador_pt2262_param
//
// PT2262-compatible remote-control encoder. A frame request latches a trinary
// address and a binary data field. These are serialised as pulse-width
// symbols of 32 slots each, followed by a 128-slot sync symbol. The word is
// repeated N_REPEAT times. Slot timing comes from a clk-enable divider (one
// tick every CLK_DIV cycles); no derived clock is generated.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   start  frame request, level-sampled while idle
//   cont   continuous mode, latched at frame start
//   stop   end the frame after the current word completes
//   addr   trit i = addr[2i+1:2i]: 00 '0', 01 '1', 1x 'F'
//   data   data bits, sent data[0] first (unused when N_DATA = 0)
//   cod_o  encoded serial output (drives the RF modulator enable)
//   sync   high during the sync symbol
//   busy   frame in progress
//   done   one-cycle pulse at frame end
// ---------------------------------------------------------------------------
module codificador_pt2262_param #(
  parameter int N_ADDR   = 8,    // 1..12 address trits
  parameter int N_DATA   = 4,    // 0..6 data bits, N_ADDR+N_DATA <= 16
  parameter int CLK_DIV  = 250,  // clk cycles per slot, >= 2
  parameter int N_REPEAT = 4     // 1..15 words per frame
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   cont,
  input  logic                                   stop,
  input  logic [2*N_ADDR-1:0]                    addr,
  input  logic [((N_DATA > 0) ? N_DATA : 1)-1:0] data,
  output logic                                   cod_o,
  output logic                                   sync,
  output logic                                   busy,
  output logic                                   done
);

  localparam int DATA_W = (N_DATA > 0) ? N_DATA : 1;
  localparam int N_SYM  = N_ADDR + N_DATA;
  localparam int SYM_W  = (N_SYM > 1) ? $clog2(N_SYM) : 1;
  localparam int DIV_W  = $clog2(CLK_DIV);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_SYNC = 2'd3;

  // Symbol codes used by the output decoder.
  localparam logic [1:0] TRIT_0 = 2'd0;
  localparam logic [1:0] TRIT_1 = 2'd1;
  localparam logic [1:0] TRIT_F = 2'd2;

  logic [1:0]          state_q,     state_d;
  logic [DIV_W-1:0]    div_q,       div_d;
  logic [6:0]          slot_q,      slot_d;   // only [4:0] used outside SYNC
  logic [SYM_W-1:0]    sym_q,       sym_d;    // addr trits, then data bits
  logic [3:0]          rep_q,       rep_d;
  logic [2*N_ADDR-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic                cont_q,      cont_d;
  logic                stop_pend_q, stop_pend_d;
  logic                done_q,      done_d;

  logic tick;
  logic load_frame;

  assign busy = (state_q != S_IDLE);
  assign sync = (state_q == S_SYNC);
  assign done = done_q;
  assign tick = busy && (div_q == DIV_W'(CLK_DIV - 1));

  // ---------------------------------------------------------------- next state
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    slot_d      = slot_q;
    sym_d       = sym_q;
    rep_d       = rep_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q | (busy & stop);
    done_d      = 1'b0;
    load_frame  = 1'b0;

    if (state_q == S_IDLE) begin
      div_d      = '0;
      load_frame = start;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (state_q == S_SYNC) begin
          if (slot_q == 7'd127) begin
            if ((rep_q < 4'(N_REPEAT - 1)) && !stop_pend_q) begin
              rep_d   = rep_q + 1'b1;
              state_d = S_ADDR;
              sym_d   = '0;
              slot_d  = '0;
            end else begin
              done_d = 1'b1;
              if (cont_q && !stop_pend_q) begin
                // Continuous mode: next frame starts with no idle cycle.
                load_frame = 1'b1;
              end else begin
                state_d     = S_IDLE;
                slot_d      = '0;
                sym_d       = '0;
                rep_d       = '0;
                stop_pend_d = 1'b0;
              end
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          // ADDR / DATA: 32-slot symbols, symbol index runs across both.
          if (slot_q[4:0] == 5'd31) begin
            slot_d = '0;
            if (sym_q == SYM_W'(N_SYM - 1)) begin
              state_d = S_SYNC;
              sym_d   = '0;
            end else begin
              sym_d = sym_q + 1'b1;
              if (sym_q == SYM_W'(N_ADDR - 1)) state_d = S_DATA;
            end
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
    end

    if (load_frame) begin
      addr_d  = addr;
      data_d  = data;
      cont_d  = cont;
      rep_d   = '0;
      sym_d   = '0;
      slot_d  = '0;
      div_d   = '0;
      state_d = S_ADDR;
    end
  end

  // ----------------------------------------------------------------- registers
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      slot_q      <= '0;
      sym_q       <= '0;
      rep_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      slot_q      <= slot_d;
      sym_q       <= sym_d;
      rep_q       <= rep_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // ------------------------------------------------------------ output decode
  // Each 32-slot symbol is two 16-slot halves. A half is high for slots 0-3
  // when its bit is 0 and for slots 0-11 when its bit is 1. '0' = (0,0),
  // '1' = (1,1), 'F' = (0,1).
  logic [1:0] sym_code;
  logic       half_bit;

  always_comb begin
    sym_code = TRIT_0;
    for (int i = 0; i < N_ADDR; i++) begin
      if (int'(sym_q) == i) sym_code = addr_q[2*i+1] ? TRIT_F : {1'b0, addr_q[2*i]};
    end
    for (int j = 0; j < N_DATA; j++) begin
      if (int'(sym_q) == N_ADDR + j) sym_code = data_q[j] ? TRIT_1 : TRIT_0;
    end
    half_bit = (sym_code == TRIT_1) || ((sym_code == TRIT_F) && slot_q[4]);

    cod_o = 1'b0;
    case (state_q)
      S_ADDR, S_DATA: cod_o = (slot_q[3:2] == 2'b00) || (half_bit && (slot_q[3:2] != 2'b11));
      S_SYNC:         cod_o = (slot_q[6:2] == 5'd0);
      default:        cod_o = 1'b0;
    endcase
  end

  generate
    if (N_DATA == 0) begin : g_no_data
      logic unused_data;
      assign unused_data = ^data_q;
    end
  endgenerate

endmodule
